// File: rtl/br_enc_bin2gray.sv
// Binary-to-Gray encoder.
module br_enc_bin2gray #(
  parameter int Width = 3
) (
  input  logic [Width-1:0] bin,
  output logic [Width-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/br_enc_gray2bin.sv
// Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module br_enc_gray2bin #(
  parameter int Width = 3
) (
  input  logic [Width-1:0] gray,
  output logic [Width-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/br_enc_gray_incr.sv
// Gray-coded counter register; the binary view is decoded combinationally from the register.
module br_enc_gray_incr #(
  parameter int Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
  output logic [Width-1:0] gray,
  output logic [Width-1:0] bin
);

  logic [Width-1:0] bin_next;
  logic [Width-1:0] gray_next;

  br_enc_gray2bin #(.Width(Width)) u_gray2bin (
    .gray (gray),
    .bin  (bin)
  );

  assign bin_next = bin + Width'(1);

  br_enc_bin2gray #(.Width(Width)) u_bin2gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gray <= '0;
    end else if (incr) begin
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/br_fifo_gray_ptr_ctrl.sv
// FIFO pointer controller: Gray-coded read/write pointers with occupancy and full/empty status.
module br_fifo_gray_ptr_ctrl #(
  parameter int Depth     = 4,
  parameter int AddrWidth = $clog2(Depth),
  parameter int PtrWidth  = AddrWidth + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  output logic                 push_ready,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [AddrWidth-1:0] wr_addr,
  output logic [AddrWidth-1:0] rd_addr,
  output logic [PtrWidth-1:0]  wr_ptr_gray,
  output logic [PtrWidth-1:0]  rd_ptr_gray,
  output logic [PtrWidth-1:0]  items,
  output logic                 full,
  output logic                 empty
);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("Depth must be a power of two and at least 2");
  end
  if (AddrWidth != $clog2(Depth) || PtrWidth != AddrWidth + 1) begin : g_bad_width
    $error("AddrWidth and PtrWidth are derived and must not be overridden");
  end

  logic [PtrWidth-1:0] wr_bin;
  logic [PtrWidth-1:0] rd_bin;
  logic                push_fire;
  logic                pop_fire;

  br_enc_gray_incr #(.Width(PtrWidth)) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .incr (push_fire),
    .gray (wr_ptr_gray),
    .bin  (wr_bin)
  );

  br_enc_gray_incr #(.Width(PtrWidth)) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .incr (pop_fire),
    .gray (rd_ptr_gray),
    .bin  (rd_bin)
  );

  // The extra wrap bit makes the modular difference distinguish full from empty.
  assign items      = wr_bin - rd_bin;
  assign empty      = (items == '0);
  assign full       = (items == PtrWidth'(Depth));
  assign push_ready = !full && !rst;
  assign pop_valid  = !empty && !rst;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;
  assign wr_addr    = wr_bin[AddrWidth-1:0];
  assign rd_addr    = rd_bin[AddrWidth-1:0];

  a_push_hold : assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=> push_valid)
    else $error("push_valid dropped before the push fired");

  a_occupancy : assert property (@(posedge clk) disable iff (rst)
    items <= PtrWidth'(Depth))
    else $error("occupancy exceeds Depth");

  a_pop_valid : assert property (@(posedge clk) disable iff (rst)
    !pop_valid |=> (rd_ptr_gray == $past(rd_ptr_gray)))
    else $error("read pointer advanced without pop_valid");

endmodule

// File: tb/tb_br_fifo_gray_ptr_ctrl.sv
// Directed and random bench for br_fifo_gray_ptr_ctrl against a push/pop count model.
module tb_br_fifo_gray_ptr_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_valid = 1'b0;
  logic          pop_ready = 1'b0;
  logic          push_ready;
  logic          pop_valid;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] wr_ptr_gray;
  logic [PW-1:0] rd_ptr_gray;
  logic [PW-1:0] items;
  logic          full;
  logic          empty;

  int total = 0;
  int bad   = 0;

  // Model: lifetime push/pop counts plus the queue of addresses written.
  int wr_n = 0;
  int rd_n = 0;
  int addrq[$];

  br_fifo_gray_ptr_ctrl #(.Depth(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .pop_valid   (pop_valid),
    .pop_ready   (pop_ready),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .items       (items),
    .full        (full),
    .empty       (empty)
  );

  initial forever #5 clk = ~clk;

  function automatic int gray_of(int n);
    int b;
    b = n % (2 * DEPTH);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int occ;
    occ = wr_n - rd_n;
    chk("items", 32'(items), 32'(occ));
    chk("empty", 32'(empty), 32'(occ == 0));
    chk("full", 32'(full), 32'(occ == DEPTH));
    chk("push_ready", 32'(push_ready), 32'(occ < DEPTH));
    chk("pop_valid", 32'(pop_valid), 32'(occ > 0));
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray_of(wr_n)));
    chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(gray_of(rd_n)));
    chk("wr_addr", 32'(wr_addr), 32'(wr_n % DEPTH));
    chk("rd_addr", 32'(rd_addr), 32'((occ > 0) ? addrq[0] : rd_n % DEPTH));
  endtask

  // One clock: drive inputs, check at the falling edge, then advance the model past the rising edge.
  task automatic cycle(input bit pv, input bit pr, input bit r, output bit pf);
    bit qf;
    int occ;
    logic [PW-1:0] prev_wg;
    logic [PW-1:0] prev_rg;
    push_valid = pv;
    pop_ready  = pr;
    rst        = r;
    @(negedge clk);
    occ = wr_n - rd_n;
    if (r) begin
      chk("rst_push_ready", 32'(push_ready), 32'd0);
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    end else begin
      check_all();
    end
    pf = pv && !r && (occ < DEPTH);
    qf = pr && !r && (occ > 0);
    prev_wg = wr_ptr_gray;
    prev_rg = rd_ptr_gray;
    @(posedge clk);
    #1;
    if (r) begin
      wr_n = 0;
      rd_n = 0;
      addrq.delete();
    end else begin
      if (pf) begin
        addrq.push_back(wr_n % DEPTH);
        wr_n++;
        chk("wr_gray_1bit", 32'($countones(wr_ptr_gray ^ prev_wg)), 32'd1);
      end
      if (qf) begin
        void'(addrq.pop_front());
        rd_n++;
        chk("rd_gray_1bit", 32'($countones(rd_ptr_gray ^ prev_rg)), 32'd1);
      end
    end
  endtask

  initial begin
    int seq[4];
    bit pf;
    bit hold;
    bit pv;
    bit pr;
    bit r;
    seq = '{1, 3, 2, 6};

    cycle(0, 0, 1, pf);
    cycle(0, 0, 1, pf);
    cycle(0, 0, 0, pf);
    chk("idle_items", 32'(items), 32'd0);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_push_ready", 32'(push_ready), 32'd1);
    chk("idle_pop_valid", 32'(pop_valid), 32'd0);
    chk("idle_wr_gray", 32'(wr_ptr_gray), 32'd0);
    chk("idle_rd_gray", 32'(rd_ptr_gray), 32'd0);

    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, pf);
      chk("seq_wr_gray", 32'(wr_ptr_gray), 32'(seq[i]));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_push_ready", 32'(push_ready), 32'd0);
    cycle(1, 0, 0, pf);
    chk("held_push_fire", 32'(pf), 32'd0);
    chk("held_wr_gray", 32'(wr_ptr_gray), 32'd6);

    cycle(1, 1, 0, pf);
    chk("full_pushpop_items", 32'(items), 32'd3);
    chk("full_pushpop_wr_gray", 32'(wr_ptr_gray), 32'd6);
    cycle(1, 0, 0, pf);
    chk("late_push_items", 32'(items), 32'd4);

    for (int i = 0; i < 3; i++) cycle(0, 1, 0, pf);
    chk("drain_items", 32'(items), 32'd1);
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 0, pf);
      chk("lockstep_items", 32'(items), 32'd1);
    end

    cycle(0, 1, 0, pf);
    chk("empty_after_drain", 32'(empty), 32'd1);
    cycle(0, 1, 0, pf);
    cycle(0, 1, 0, pf);
    chk("empty_pop_rd_gray", 32'(rd_ptr_gray), 32'(gray_of(rd_n)));
    cycle(1, 1, 0, pf);
    chk("push_then_pop_valid", 32'(pop_valid), 32'd1);

    cycle(1, 0, 0, pf);
    cycle(1, 0, 0, pf);
    chk("pre_rst_items", 32'(items), 32'd3);
    cycle(1, 0, 1, pf);
    chk("post_rst_items", 32'(items), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_wr_gray", 32'(wr_ptr_gray), 32'd0);
    cycle(0, 0, 0, pf);

    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      pv = hold ? 1'b1 : 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      cycle(pv, pr, r, pf);
      hold = pv && !pf && !r;
    end
    cycle(hold, 0, 1, pf);
    cycle(0, 0, 0, pf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
